// File: rtl/div8_seq.sv
// rtl/div8_seq.sv - sequential unsigned 8-bit restoring divider
// Resolves one quotient bit per clock; divisor==0 short-cuts straight to DONE.
module div8_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [7:0] divisor,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_quot;
   logic [7:0] r_rem;
   logic [7:0] r_dvs;
   logic [2:0] r_cnt;
   logic       r_dbz;
   logic [8:0] w_shift;
   logic [8:0] w_trial;
   logic       w_accept;

   // The quotient register doubles as the dividend shift register.
   assign w_shift  = {r_rem, r_quot[7]};
   assign w_trial  = w_shift - {1'b0, r_dvs};
   assign w_accept = (r_state == S_IDLE) && start;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = (divisor == 8'd0) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (r_cnt == 3'd7) begin
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_quot <= 8'd0;
         r_rem  <= 8'd0;
         r_dvs  <= 8'd0;
         r_cnt  <= 3'd0;
         r_dbz  <= 1'b0;
      end else if (w_accept) begin
         if (divisor == 8'd0) begin
            r_quot <= 8'hFF;
            r_rem  <= dividend;
            r_dbz  <= 1'b1;
         end else begin
            r_dvs  <= divisor;
            r_quot <= dividend;
            r_rem  <= 8'd0;
            r_cnt  <= 3'd0;
            r_dbz  <= 1'b0;
         end
      end else if (r_state == S_CALC) begin
         if (!w_trial[8]) begin
            r_rem  <= w_trial[7:0];
            r_quot <= {r_quot[6:0], 1'b1};
         end else begin
            r_rem  <= w_shift[7:0];
            r_quot <= {r_quot[6:0], 1'b0};
         end
         r_cnt <= r_cnt + 3'd1;
      end
   end

   assign ready       = (r_state == S_IDLE);
   assign busy        = (r_state == S_CALC);
   assign done        = (r_state == S_DONE);
   assign quotient    = r_quot;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div8_seq.sv
// tb/tb_div8_seq.sv - self-checking bench for div8_seq
// Directed steps plus a randomized back-to-back sweep against a plain-arithmetic model.
module tb_div8_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       ready;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;
   bit onehot_en = 0;

   div8_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (onehot_en && rst_n === 1'b1) begin
         check("onehot", {31'd0, $onehot({ready, busy, done})}, 32'd1);
      end
   end

   function automatic void model(input int a, input int b, output int q, output int r, output int z);
      if (b == 0) begin
         q = 255; r = a; z = 1;
      end else begin
         q = a / b; r = a % b; z = 0;
      end
   endfunction

   // Waits (from a negedge) until done is seen; returns the number of edges waited.
   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input int a, input int b, input int lat);
      int q, r, z;
      model(a, b, q, r, z);
      check({tag, "_lat"}, lat, (b == 0) ? 0 : 8);
      check({tag, "_q"}, quotient, q);
      check({tag, "_r"}, remainder, r);
      check({tag, "_dbz"}, div_by_zero, z);
   endtask

   task automatic run_op(input string tag, input int a, input int b);
      int lat;
      @(negedge clk);
      start    = 1'b1;
      dividend = a[7:0];
      divisor  = b[7:0];
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      check_result(tag, a, b, lat);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_ready_after"}, ready, 1);
   endtask

   initial begin
      int lat;
      int q, r, z;
      int a, b;
      int last_accept;

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      rst_n     = 1'b1;
      onehot_en = 1;

      run_op("d200_7", 200, 7);
      run_op("d255_1", 255, 1);
      run_op("d5_9", 5, 9);
      run_op("d255_255", 255, 255);
      run_op("d0_3", 0, 3);
      run_op("d77_0", 77, 0);
      run_op("d77_7", 77, 7);

      // A start pulse mid-calculation must be ignored.
      @(negedge clk);
      start = 1'b1; dividend = 8'd100; divisor = 8'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      check("ign_ready", ready, 0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("ign_busy", busy, 1);
      wait_done(lat);
      check("ign_lat", lat, 3);
      check("ign_q", quotient, 33);
      check("ign_r", remainder, 1);
      @(posedge clk);
      @(negedge clk);
      check("ign_ready_after", ready, 1);

      // Reset mid-calculation discards the partial result.
      @(negedge clk);
      start = 1'b1; dividend = 8'd180; divisor = 8'd11;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_ready", ready, 1);
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      check("mrst_q", quotient, 0);
      check("mrst_r", remainder, 0);
      check("mrst_dbz", div_by_zero, 0);
      lat = 0;
      repeat (6) begin
         @(posedge clk);
         @(negedge clk);
         if (done === 1'b1) lat++;
      end
      check("mrst_no_done", lat, 0);
      run_op("d180_11", 180, 11);

      // Back-to-back sweep with start held high.
      @(negedge clk);
      start       = 1'b1;
      last_accept = -1;
      for (int i = 0; i < 2000; i++) begin
         a = $urandom_range(0, 255);
         b = $urandom_range(1, 255);
         dividend = a[7:0];
         divisor  = b[7:0];
         check("swp_ready", ready, 1);
         @(posedge clk);
         if (last_accept >= 0) check("swp_period", cycle - last_accept, 10);
         last_accept = cycle;
         @(negedge clk);
         wait_done(lat);
         model(a, b, q, r, z);
         check("swp_lat", lat, 8);
         check("swp_q", quotient, q);
         check("swp_r", remainder, r);
         check("swp_ident", quotient * b + remainder, a);
         check("swp_bound", {31'd0, remainder < b}, 1);
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
